regfile_nport_sb: RTL and testbench

Parametrised integer register file for the RV32 core. It has two asynchronous read ports and one synchronous write port, with register 0 hardwired to zero. It adds an optional same-cycle write-to-read bypass, a per-register pending-write scoreboard for load/long-latency hazard detection, and a sequential soft-clear engine that zeroes the file one entry per cycle. It sits between decode (read/alloc) and writeback (write).

---
 rtl/regfile_nport_sb.sv | 93 +++++++++
 tb/tb_regfile_nport_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nport_sb.sv
// regfile_nport_sb: 2R1W integer register file with hardwired x0, write bypass, pending-write scoreboard and soft clear
module regfile_nport_sb #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_addr,
    output logic            busy_a,
    output logic            busy_b,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);
    typedef enum logic {IDLE, CLEAR} state_e;
    state_e state_q, state_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic clearing, wr_en, al_en, byp_a, byp_b;

    assign clearing = state_q == CLEAR;
    assign wr_en = we & ~clearing & ~clr_req & (waddr != '0);
    assign al_en = alloc_en & ~clearing & ~clr_req & (alloc_addr != '0);
    assign byp_a = BYPASS & we & ~clearing & (waddr == raddr_a) & (waddr != '0);
    assign byp_b = BYPASS & we & ~clearing & (waddr == raddr_b) & (waddr != '0);
    assign rdata_a = (raddr_a == '0) ? '0 : byp_a ? wdata : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : byp_b ? wdata : regs_q[raddr_b];
    // an in-flight write retires the pending bit early unless a new allocation lands in the same cycle
    assign busy_a = busy_q[raddr_a] & ~(byp_a & ~(alloc_en & (alloc_addr == raddr_a)));
    assign busy_b = busy_q[raddr_b] & ~(byp_b & ~(alloc_en & (alloc_addr == raddr_b)));
    assign clr_busy = clearing;
    assign clr_done = done_q;

    // clear sequencing and scoreboard update; a clear request wins over that cycle's write/alloc
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        busy_d = busy_q;
        if (clearing) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = IDLE;
                done_d = 1'b1;
            end
        end else if (clr_req) begin
            state_d = CLEAR;
            cnt_d = AW'(1);
            busy_d = '0;
        end else begin
            if (wr_en) busy_d[waddr] = 1'b0;
            if (al_en) busy_d[alloc_addr] = 1'b1;
        end
    end

    // control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            done_q <= 1'b0;
            busy_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    // storage array: clear engine zeroes one entry per cycle, otherwise the writeback port writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (clearing) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_regfile_nport_sb.sv
// tb_regfile_nport_sb: scoreboard bench for the default and a small BYPASS=0 register file
module tb_regfile_nport_sb;
    localparam int XL = 32, NR = 32, AWL = 5, XS = 16, NS = 4, AWS = 2;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic we_l, al_l, cr_l, bza_l, bzb_l, cb_l, cd_l;
    logic [AWL-1:0] wa_l, ra_l, rb_l, aa_l;
    logic [XL-1:0] wd_l, rda_l, rdb_l;
    logic we_s, al_s, cr_s, bza_s, bzb_s, cb_s, cd_s;
    logic [AWS-1:0] wa_s, ra_s, rb_s, aa_s;
    logic [XS-1:0] wd_s, rda_s, rdb_s;

    regfile_nport_sb #(.XLEN(XL), .NREGS(NR), .BYPASS(1'b1)) dut_l (
        .clk(clk), .reset_n(reset_n), .we(we_l), .waddr(wa_l), .wdata(wd_l),
        .raddr_a(ra_l), .raddr_b(rb_l), .rdata_a(rda_l), .rdata_b(rdb_l),
        .alloc_en(al_l), .alloc_addr(aa_l), .busy_a(bza_l), .busy_b(bzb_l),
        .clr_req(cr_l), .clr_busy(cb_l), .clr_done(cd_l));

    regfile_nport_sb #(.XLEN(XS), .NREGS(NS), .BYPASS(1'b0)) dut_s (
        .clk(clk), .reset_n(reset_n), .we(we_s), .waddr(wa_s), .wdata(wd_s),
        .raddr_a(ra_s), .raddr_b(rb_s), .rdata_a(rda_s), .rdata_b(rdb_s),
        .alloc_en(al_s), .alloc_addr(aa_s), .busy_a(bza_s), .busy_b(bzb_s),
        .clr_req(cr_s), .clr_busy(cb_s), .clr_done(cd_s));

    // reference model state for whichever DUT is selected
    int sel, mn, mbyp, mclr, mpos;
    logic [31:0] mmask;
    logic [31:0] mreg [32];
    bit mbusy [32];
    bit mdone;
    bit iwe, ial, icr;
    int iwa, iaa;
    logic [31:0] iwd;

    typedef struct {
        int sel;
        logic [31:0] ra, rb;
        logic ba, bb, cb, cd;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] exp_rd(int a);
        if (a == 0) return 32'h0;
        if (mbyp != 0 && mclr == 0 && iwe && iwa == a) return iwd & mmask;
        return mreg[a];
    endfunction

    function automatic logic exp_bz(int a);
        if (a == 0) return 1'b0;
        return mbusy[a] && !(mbyp != 0 && mclr == 0 && iwe && iwa == a && !(ial && iaa == a));
    endfunction

    task automatic model_reset();
        foreach (mreg[i]) mreg[i] = 32'h0;
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mclr = 0;
        mpos = 0;
        mdone = 1'b0;
    endtask

    task automatic model_edge();
        if (mclr > 0) begin
            mreg[mpos] = 32'h0;
            mpos++;
            mclr--;
            mdone = (mclr == 0);
        end else begin
            mdone = 1'b0;
            if (icr) begin
                foreach (mbusy[i]) mbusy[i] = 1'b0;
                mclr = mn - 1;
                mpos = 1;
            end else begin
                if (iwe && iwa != 0) begin
                    mreg[iwa] = iwd & mmask;
                    mbusy[iwa] = 1'b0;
                end
                if (ial && iaa != 0) mbusy[iaa] = 1'b1;
            end
        end
    endtask

    task automatic step(bit we, int wa, logic [31:0] wd, int ra, int rb, bit al, int aa, bit cr);
        exp_t e;
        iwe = we; iwa = wa; iwd = wd; ial = al; iaa = aa; icr = cr;
        we_l = 0; al_l = 0; cr_l = 0; we_s = 0; al_s = 0; cr_s = 0;
        if (sel == 0) begin
            we_l = we; wa_l = wa[AWL-1:0]; wd_l = wd; ra_l = ra[AWL-1:0]; rb_l = rb[AWL-1:0];
            al_l = al; aa_l = aa[AWL-1:0]; cr_l = cr;
        end else begin
            we_s = we; wa_s = wa[AWS-1:0]; wd_s = wd[XS-1:0]; ra_s = ra[AWS-1:0]; rb_s = rb[AWS-1:0];
            al_s = al; aa_s = aa[AWS-1:0]; cr_s = cr;
        end
        e.sel = sel;
        e.ra = exp_rd(ra);
        e.rb = exp_rd(rb);
        e.ba = exp_bz(ra);
        e.bb = exp_bz(rb);
        e.cb = mclr > 0;
        e.cd = mdone;
        q.push_back(e);
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic idle(int ra, int rb);
        step(0, 0, 32'h0, ra, rb, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        idle(1, 2);
        idle(3, 0);
        reset_n = 1'b1;
    endtask

    task automatic rand_step();
        step($urandom_range(1, 0) == 1, $urandom_range(mn - 1, 0), $urandom,
             $urandom_range(mn - 1, 0), $urandom_range(mn - 1, 0),
             $urandom_range(9, 0) < 3, $urandom_range(mn - 1, 0), $urandom_range(49, 0) == 0);
    endtask

    // monitor: compares every presented cycle against the oldest expectation
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.sel == 0) begin
                chk("rdata_a", rda_l, e.ra);
                chk("rdata_b", rdb_l, e.rb);
                chk("busy_a", 32'(bza_l), 32'(e.ba));
                chk("busy_b", 32'(bzb_l), 32'(e.bb));
                chk("clr_busy", 32'(cb_l), 32'(e.cb));
                chk("clr_done", 32'(cd_l), 32'(e.cd));
            end else begin
                chk("s_rdata_a", 32'(rda_s), e.ra);
                chk("s_rdata_b", 32'(rdb_s), e.rb);
                chk("s_busy_a", 32'(bza_s), 32'(e.ba));
                chk("s_busy_b", 32'(bzb_s), 32'(e.bb));
                chk("s_clr_busy", 32'(cb_s), 32'(e.cb));
                chk("s_clr_done", 32'(cd_s), 32'(e.cd));
            end
        end
    end

    initial begin
        sel = 0; mn = NR; mbyp = 1; mmask = 32'hFFFF_FFFF;
        iwe = 0; ial = 0; icr = 0; iwa = 0; iaa = 0; iwd = 0;
        we_l = 0; al_l = 0; cr_l = 0; wa_l = 0; wd_l = 0; ra_l = 0; rb_l = 0; aa_l = 0;
        we_s = 0; al_s = 0; cr_s = 0; wa_s = 0; wd_s = 0; ra_s = 0; rb_s = 0; aa_s = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        // write/read, bypass and x0
        step(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
        idle(5, 5);
        step(1, 0, 32'h12345678, 5, 0, 0, 0, 0);
        idle(0, 5);
        // scoreboard: alloc, write retire, alloc+write collision
        step(0, 0, 0, 7, 0, 1, 7, 0);
        idle(7, 7);
        step(1, 7, 32'h77, 7, 5, 0, 0, 0);
        idle(7, 7);
        step(1, 7, 32'h78, 7, 7, 1, 7, 0);
        idle(7, 7);
        // soft clear with a write attempted during it
        for (int r = 1; r < NR; r++) step(1, r, 32'hA5A5_0000 + r, r, r - 1, 0, 0, 0);
        step(0, 0, 0, 1, 31, 0, 0, 1);
        for (int i = 0; i < NR - 1; i++)
            step(1, 3, 32'hFFFF, 3, $urandom_range(NR - 1, 0), $urandom_range(1, 0) == 1, 9, 1);
        for (int r = 0; r < NR; r += 2) idle(r, r + 1);
        // reset in the middle of a clear, then a full clear
        for (int r = 1; r < NR; r += 3) step(1, r, $urandom, r, 0, 1, r, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) idle(i + 10, 1);
        do_reset();
        for (int r = 0; r < NR; r += 2) idle(r, r + 1);
        step(1, 4, 32'h4444, 4, 0, 0, 0, 1);
        for (int i = 0; i < NR + 1; i++) idle(4, i);
        for (int i = 0; i < 400; i++) rand_step();
        // small BYPASS=0 instance
        sel = 1; mn = NS; mbyp = 0; mmask = 32'h0000_FFFF;
        do_reset();
        step(1, 3, 32'hBEEF, 3, 3, 0, 0, 0);
        idle(3, 0);
        step(0, 0, 0, 3, 2, 1, 2, 0);
        step(1, 2, 32'h1234, 2, 3, 0, 0, 0);
        idle(2, 3);
        step(0, 0, 0, 3, 2, 0, 0, 1);
        for (int i = 0; i < NS + 1; i++) idle(3, i);
        for (int i = 0; i < 150; i++) rand_step();
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
